// File: rtl/sw_evt_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sw_evt_pkg
// Description : Shared types and constants for the switch event encoder.
//               Holds the press-tracking state encoding, the switch code
//               names used by the downstream queue counter, and the width
//               of the switch code.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_evt_pkg;

    localparam int NUM_SW = 4;
    localparam int CODE_W = $clog2(NUM_SW);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        EMIT    = 2'd2,
        REJECT  = 2'd3
    } evt_state_t;

    // Switch codes as seen by the queue counter.
    localparam logic [CODE_W-1:0] SW_ADD1 = 2'd0;
    localparam logic [CODE_W-1:0] SW_ADD2 = 2'd1;
    localparam logic [CODE_W-1:0] SW_ADD3 = 2'd2;
    localparam logic [CODE_W-1:0] SW_SUB  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : One switch channel: a SYNC_STAGES-deep synchroniser followed
//               by a stable-sample debounce counter and the debounced level.
// Ports       : CLOCK_50 - system clock
//               rst      - synchronous active-high reset
//               i_sw     - raw asynchronous switch level
//               o_db     - debounced level
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic i_sw,
    output logic o_db
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_db;
    logic                   w_s;

    assign w_s  = r_sync[SYNC_STAGES-1];
    assign o_db = r_db;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // The counter measures how long the synchronised input has disagreed
    // with the debounced level; any agreement restarts the measurement.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (w_s == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == C_CNT_LAST) begin
            r_db  <= ~r_db;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : switch_event_encoder
// Description : Conditions the command switches and turns each qualified
//               press/release into a single-cycle valid+code event, or a
//               reject pulse for presses that are too short or involve more
//               than one switch.
// Ports       : CLOCK_50   - system clock, 50 MHz
//               rst        - synchronous active-high reset
//               sw         - raw switch levels, bit i is switch i
//               evt_valid  - one-cycle pulse, qualified press completed
//               evt_code   - index of the pressed switch, held between events
//               evt_reject - one-cycle pulse, press discarded
//               busy       - a press is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module switch_event_encoder
    import sw_evt_pkg::*;
#(
    parameter int NUM_SW          = sw_evt_pkg::NUM_SW,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int MIN_HOLD_CYCLES = 100
) (
    input  logic                      CLOCK_50,
    input  logic                      rst,
    input  logic [NUM_SW-1:0]         sw,
    output logic                      evt_valid,
    output logic [$clog2(NUM_SW)-1:0] evt_code,
    output logic                      evt_reject,
    output logic                      busy
);

    localparam int CW     = $clog2(NUM_SW);
    localparam int HOLD_W = $clog2(MIN_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] C_HOLD_MIN = HOLD_W'(MIN_HOLD_CYCLES);

    logic [NUM_SW-1:0] w_db;
    logic              w_any_db;
    logic [CW-1:0]     w_hi_code;
    logic              w_multi_now;
    logic              w_other_set;

    evt_state_t        r_state;
    logic [CW-1:0]     r_code;
    logic [HOLD_W-1:0] r_hold;
    logic              r_multi;
    logic              r_valid;
    logic              r_reject;
    logic              r_busy;
    logic [CW-1:0]     r_evt_code;

    generate
        for (genvar g = 0; g < NUM_SW; g++) begin : g_debounce
            sw_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .CLOCK_50 (CLOCK_50),
                .rst      (rst),
                .i_sw     (sw[g]),
                .o_db     (w_db[g])
            );
        end
    endgenerate

    assign w_any_db = |w_db;

    // Highest-index set bit wins (SW3 > SW2 > SW1 > SW0).
    always_comb begin
        w_hi_code = SW_ADD1;
        for (int i = 0; i < NUM_SW; i++) begin
            if (w_db[i]) begin
                w_hi_code = CW'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign w_multi_now = |(w_db & (w_db - NUM_SW'(1)));
    assign w_other_set = |(w_db & ~(NUM_SW'(1) << r_code));

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state    <= IDLE;
            r_code     <= SW_ADD1;
            r_hold     <= '0;
            r_multi    <= 1'b0;
            r_valid    <= 1'b0;
            r_reject   <= 1'b0;
            r_busy     <= 1'b0;
            r_evt_code <= SW_ADD1;
        end else begin
            r_valid  <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_db) begin
                        r_code  <= w_hi_code;
                        r_hold  <= HOLD_W'(1);
                        r_multi <= w_multi_now;
                        r_state <= PRESSED;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                PRESSED: begin
                    if (w_any_db) begin
                        if (r_hold != C_HOLD_MIN) begin
                            r_hold <= r_hold + HOLD_W'(1);
                        end
                        if (w_other_set) begin
                            r_multi <= 1'b1;
                        end
                    end else if ((r_hold >= C_HOLD_MIN) && !r_multi) begin
                        r_state    <= EMIT;
                        r_valid    <= 1'b1;
                        r_evt_code <= r_code;
                    end else begin
                        r_state  <= REJECT;
                        r_reject <= 1'b1;
                    end
                end
                EMIT, REJECT: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid  = r_valid;
    assign evt_reject = r_reject;
    assign busy       = r_busy;
    assign evt_code   = r_evt_code;

endmodule
`default_nettype wire

// File: tb/tb_switch_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_event_encoder
// Description : Directed self-checking bench for switch_event_encoder with
//               DEBOUNCE_CYCLES=4, MIN_HOLD_CYCLES=8, SYNC_STAGES=2.
//               A raw press of N cycles (N >= 4) yields a debounced high of
//               N cycles, so hold_cnt reaches N at release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_event_encoder;

    logic       CLOCK_50 = 1'b0;
    logic       rst      = 1'b1;
    logic [3:0] sw       = 4'b0000;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_reject;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    int         n_valid  = 0;
    int         n_reject = 0;
    int         n_both   = 0;
    logic [1:0] last_code = 2'd0;

    switch_event_encoder #(
        .NUM_SW          (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .MIN_HOLD_CYCLES (8)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .sw         (sw),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_reject (evt_reject),
        .busy       (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Event counters sampled on the inactive edge.
    always @(negedge CLOCK_50) begin
        if (evt_valid) begin
            n_valid   = n_valid + 1;
            last_code = evt_code;
        end
        if (evt_reject) n_reject = n_reject + 1;
        if (evt_valid && evt_reject) n_both = n_both + 1;
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic clear_counts();
        n_valid  = 0;
        n_reject = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw  = 4'b0000;
        step(2);
        n_vec += 4;
        if (evt_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid got %b want 0", evt_valid); end
        if (evt_code !== 2'd0)   begin n_err++; $display("FAIL reset_code got %0d want 0", evt_code); end
        if (evt_reject !== 1'b0) begin n_err++; $display("FAIL reset_reject got %b want 0", evt_reject); end
        if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        step(2);
        clear_counts();
    endtask

    task automatic test_basic();
        int early;
        early = 0;
        sw = 4'b0010;
        step(20);
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_held got %b want 1", busy); end
        sw = 4'b0000;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            if (evt_valid) early++;
        end
        n_vec++;
        if (early != 0) begin n_err++; $display("FAIL basic_early_valid got %0d want 0", early); end
        step(1);
        n_vec += 2;
        if (evt_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency_valid got %b want 1", evt_valid); end
        if (evt_code !== 2'd1)  begin n_err++; $display("FAIL basic_code got %0d want 1", evt_code); end
        step(1);
        n_vec++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse_width got %b want 0", evt_valid); end
        step(2);
        n_vec += 3;
        if (n_valid != 1)  begin n_err++; $display("FAIL basic_count got %0d want 1", n_valid); end
        if (n_reject != 0) begin n_err++; $display("FAIL basic_reject got %0d want 0", n_reject); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got %b want 0", busy); end
        clear_counts();
    endtask

    task automatic test_bounce();
        int busy_seen;
        busy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            sw = ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
            step(1);
            if (busy) busy_seen++;
        end
        // Include the synchroniser lag after the last bounce sample.
        sw = 4'b0001;
        step(2);
        if (busy) busy_seen++;
        n_vec++;
        if (busy_seen != 0) begin n_err++; $display("FAIL bounce_db_toggled got %0d busy cycles want 0", busy_seen); end
        step(18);
        sw = 4'b0000;
        step(12);
        n_vec += 3;
        if (n_valid != 1)     begin n_err++; $display("FAIL bounce_count got %0d want 1", n_valid); end
        if (last_code != 2'd0) begin n_err++; $display("FAIL bounce_code got %0d want 0", last_code); end
        if (n_reject != 0)    begin n_err++; $display("FAIL bounce_reject got %0d want 0", n_reject); end
        clear_counts();
    endtask

    task automatic test_short();
        // 7 cycles: hold_cnt ends at 7, one short of the minimum.
        sw = 4'b0100;
        step(7);
        sw = 4'b0000;
        step(12);
        n_vec += 2;
        if (n_reject != 1) begin n_err++; $display("FAIL short_reject got %0d want 1", n_reject); end
        if (n_valid != 0)  begin n_err++; $display("FAIL short_valid got %0d want 0", n_valid); end
        clear_counts();
        // 8 cycles: exactly the minimum hold, accepted.
        sw = 4'b0100;
        step(8);
        sw = 4'b0000;
        step(12);
        n_vec += 3;
        if (n_valid != 1)      begin n_err++; $display("FAIL minhold_valid got %0d want 1", n_valid); end
        if (last_code != 2'd2) begin n_err++; $display("FAIL minhold_code got %0d want 2", last_code); end
        if (n_reject != 0)     begin n_err++; $display("FAIL minhold_reject got %0d want 0", n_reject); end
        clear_counts();
    endtask

    task automatic test_multi();
        sw = 4'b1000;
        step(15);
        sw = 4'b1010;
        step(10);
        sw = 4'b0000;
        step(12);
        n_vec += 3;
        if (n_reject != 1) begin n_err++; $display("FAIL multi_late_reject got %0d want 1", n_reject); end
        if (n_valid != 0)  begin n_err++; $display("FAIL multi_late_valid got %0d want 0", n_valid); end
        if (evt_code !== 2'd2) begin n_err++; $display("FAIL multi_code_held got %0d want 2", evt_code); end
        clear_counts();
        sw = 4'b1010;
        step(20);
        sw = 4'b0000;
        step(12);
        n_vec += 2;
        if (n_reject != 1) begin n_err++; $display("FAIL multi_sim_reject got %0d want 1", n_reject); end
        if (n_valid != 0)  begin n_err++; $display("FAIL multi_sim_valid got %0d want 0", n_valid); end
        clear_counts();
    endtask

    task automatic test_reset_mid();
        sw = 4'b0001;
        step(12);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_vec += 3;
        if (busy !== 1'b0)       begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
        if (evt_valid !== 1'b0)  begin n_err++; $display("FAIL rstmid_valid got %b want 0", evt_valid); end
        if (evt_code !== 2'd0)   begin n_err++; $display("FAIL rstmid_code got %0d want 0", evt_code); end
        step(20);
        sw = 4'b0000;
        step(12);
        n_vec += 3;
        if (n_valid != 1)      begin n_err++; $display("FAIL rstmid_count got %0d want 1", n_valid); end
        if (last_code != 2'd0) begin n_err++; $display("FAIL rstmid_evcode got %0d want 0", last_code); end
        if (n_reject != 0)     begin n_err++; $display("FAIL rstmid_reject got %0d want 0", n_reject); end
        clear_counts();
    endtask

    task automatic test_back_to_back();
        sw = 4'b1000;
        step(12);
        sw = 4'b0000;
        step(6);
        sw = 4'b1000;
        step(1);
        n_vec += 2;
        if (evt_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first_valid got %b want 1", evt_valid); end
        if (evt_code !== 2'd3)  begin n_err++; $display("FAIL b2b_first_code got %0d want 3", evt_code); end
        step(1);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_gap got %b want 0", busy); end
        step(10);
        sw = 4'b0000;
        step(12);
        n_vec += 3;
        if (n_valid != 2)      begin n_err++; $display("FAIL b2b_count got %0d want 2", n_valid); end
        if (last_code != 2'd3) begin n_err++; $display("FAIL b2b_code got %0d want 3", last_code); end
        if (n_reject != 0)     begin n_err++; $display("FAIL b2b_reject got %0d want 0", n_reject); end
        clear_counts();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounce();
        test_short();
        test_multi();
        test_reset_mid();
        test_back_to_back();
        n_vec++;
        if (n_both != 0) begin n_err++; $display("FAIL valid_and_reject_together got %0d want 0", n_both); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
